// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU load/store path and a DMA burst port
// Ports: clk/rst_n (async active-low); cpu_* single-word requester with combinational cpu_gnt and
// registered cpu_rvalid/cpu_rdata; dma_* burst sequencer (start/dir/base/len/wdata in, wready/rvalid/
// rdata/busy/done out); mem_* drive the memory address, write data, write enable and read enable.
module data_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_start,
  input  logic              dma_dir,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_wready,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  logic [0:0] state;
  logic dir;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0] len, idx;
  logic [SW-1:0] starve;
  logic cpu_win, dma_win;
  // rst_n gating keeps every combinational output at 0 while reset is held
  assign cpu_win = rst_n && cpu_req && (state == IDLE || starve < LIM);
  assign dma_win = rst_n && state == BURST && !cpu_win;
  assign cpu_gnt = cpu_win;
  assign dma_wready = dma_win && dir;
  assign dma_busy = state[0];
  always_comb begin
    mem_access_addr = cpu_win ? cpu_addr : dma_win ? base + ADDR_W'(idx) : '0;
    mem_write_data = cpu_win ? cpu_wdata : dma_win ? dma_wdata : '0;
    mem_write_en = cpu_win ? cpu_we : dma_win && dir;
    mem_read = cpu_win ? !cpu_we : dma_win && !dir;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dir <= 1'b0;
      base <= '0;
      len <= '0;
      idx <= '0;
      starve <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata <= '0;
      dma_done <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_win && !cpu_we;
      if (cpu_win && !cpu_we) cpu_rdata <= mem_read_data;
      dma_rvalid <= dma_win && !dir;
      if (dma_win && !dir) dma_rdata <= mem_read_data;
      dma_done <= dma_win && idx == len;
      if (state == IDLE) begin
        if (dma_start) begin
          state <= BURST;
          dir <= dma_dir;
          base <= dma_base;
          len <= dma_len;
          idx <= '0;
          starve <= '0;
        end
      end else if (cpu_win) begin
        starve <= starve + 1'b1;
      end else begin
        starve <= '0;
        idx <= idx + 1'b1;
        if (idx == len) state <= IDLE;
      end
    end
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Arbiter and burst sequencer that shares the single-port data memory between two requesters: the CPU load/store path and a DMA burst port for bulk load/dump of data memory. It sits directly in front of the data memory and drives its address, write-data, write-enable and read-enable inputs. CPU accesses have priority, limited by a starvation guard so an active DMA burst always makes progress. Read data is registered and returned one cycle after the granted access.

## Interface
- ADDR_W, 16, address width (memory address port and both requesters)
- DATA_W, 16, data word width
- LEN_W, 4, burst length field width; burst = dma_len+1 words (1..16)
- STARVE_LIMIT, 4, max consecutive CPU wins while DMA is pending
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, single word
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  combinational; access performed this cycle
- cpu_rvalid  out  1  registered; cpu_rdata valid (1 cycle after read grant)
- cpu_rdata  out  DATA_W  registered read data
- dma_start  in  1  start burst (accepted only when idle)
- dma_dir  in  1  1 = write memory, 0 = read memory
- dma_base  in  ADDR_W  burst start address
- dma_len  in  LEN_W  words minus one
- dma_wdata  in  DATA_W  current burst write word
- dma_wready  out  1  combinational; dma_wdata consumed this cycle
- dma_rvalid  out  1  registered; dma_rdata valid
- dma_rdata  out  DATA_W  registered burst read data
- dma_busy  out  1  burst in progress
- dma_done  out  1  one-cycle pulse after last beat
- mem_access_addr  out  ADDR_W  to data memory
- mem_write_data  out  DATA_W  to data memory
- mem_write_en  out  1  to data memory
- mem_read  out  1  to data memory
- mem_read_data  in  DATA_W  combinational read data from memory

## Operation
- FSM states: IDLE, BURST. IDLE -> BURST on dma_start (latch dir, base, len; beat index = 0; starve_cnt = 0). BURST -> IDLE on clock edge of last beat (index == len).
- dma_start while BURST is ignored; no latch, no error.
- Per cycle, one winner. IDLE: CPU wins if cpu_req. BURST: CPU wins if cpu_req and starve_cnt < STARVE_LIMIT (starve_cnt increments); otherwise DMA wins (starve_cnt clears). No cpu_req in BURST: DMA wins.
- Memory drive (combinational): CPU win -> addr=cpu_addr, write_en=cpu_we, read=!cpu_we, wdata=cpu_wdata. DMA win -> addr=base+index (mod 2^ADDR_W, wraps FFFF->0000), write_en=dir, read=!dir, wdata=dma_wdata. No winner -> addr, wdata, write_en, read all 0.
- dma_wready = DMA win and dir=1.
- Read win: mem_read_data captured into cpu_rdata/dma_rdata at edge; matching rvalid high next cycle only. rdata holds last value otherwise.
- dma_done registered: high the cycle after last beat, dma_busy low same cycle.

## Timing
- Reset (async assert, sync release): state IDLE, index/starve_cnt 0, all registered outputs 0 (cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata, dma_busy, dma_done). Combinational outputs 0 while rst_n low.
- Reset mid-burst aborts: no dma_done; writes already performed remain.
- cpu_gnt same cycle as cpu_req; CPU read latency 1 cycle; back-to-back grants every cycle allowed.
- Burst of N words, no contention: N cycles from first beat; dma_busy high cycle after dma_start through last beat.
- Full contention: pattern CPU×STARVE_LIMIT, DMA×1.
- dma_start and cpu_req same cycle in IDLE: CPU granted; first DMA beat next cycle.

## Test plan
- CPU write addr 3 data BEEF, then read addr 3 -> cpu_gnt both cycles, mem_write_en 1 on first; cpu_rvalid with cpu_rdata=BEEF one cycle after read.
- DMA write base 0 len 3, no CPU -> 4 consecutive beats, addr 0,1,2,3, dma_wready 4 pulses, dma_done 1 cycle after addr 3, busy then 0.
- DMA read len 7 with cpu_req held high -> grant pattern 4 CPU / 1 DMA; 8 DMA beats complete in 40 cycles; dma_rvalid 8 pulses with correct data.
- Wrap: base FFFE len 3 -> addrs FFFE, FFFF, 0000, 0001.
- rst_n low after 2 beats of 8-word burst -> all outputs 0 immediately, no dma_done; new dma_start then runs fully.
- dma_start pulsed mid-burst with different base -> ignored; original burst completes unchanged.
